// File: rtl/util_fifo_pkg.sv
// Shared definitions for the parametrised FIFO: default sizes, read-mode enum
// and a constant-evaluable ceil(log2) helper usable in parameter expressions.
package util_fifo_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/util_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset so
// that it maps onto distributed RAM.
module util_fifo_mem
  import util_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one word per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/util_fifo_param.sv
// Parametrised synchronous FIFO with optional first-word-fall-through output,
// registered status flags, occupancy count and sticky error flags.
module util_fifo_param
  import util_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int         AW   = clog2(DEPTH);
  localparam int         CW   = AW + 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("util_fifo_param: DEPTH=%0d must be a power of two and at least 4", DEPTH);
  end
  if ((AF_THRESH < 0) || (AF_THRESH > DEPTH)) begin : g_chk_af
    $error("util_fifo_param: AF_THRESH=%0d outside 0..DEPTH", AF_THRESH);
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH)) begin : g_chk_ae
    $error("util_fifo_param: AE_THRESH=%0d outside 0..DEPTH", AE_THRESH);
  end

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt;
  logic              full_r;
  logic              empty_r;
  logic              af_r;
  logic              ae_r;
  logic              ovf_r;
  logic              udf_r;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  // A full FIFO still takes a write when the head leaves in the same cycle;
  // an empty FIFO never forwards a same-cycle write to a read.
  assign rd_acc = rd_en & ~empty_r;
  assign wr_acc = wr_en & (~full_r | rd_acc);

  util_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Next occupancy; flags are derived from this so they never lag the count.
  always_comb begin
    count_nxt = count_r;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_r + 1'b1;
      2'b01:   count_nxt = count_r - 1'b1;
      default: count_nxt = count_r;
    endcase
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count_r <= count_nxt;
      full_r  <= (count_nxt == CW'(DEPTH));
      empty_r <= (count_nxt == '0);
      af_r    <= (count_nxt >= CW'(AF_THRESH));
      ae_r    <= (count_nxt <= CW'(AE_THRESH));
    end
  end

  // Sticky error flags; a new rejection in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (wr_en & ~wr_acc)  ovf_r <= 1'b1;
      else if (clr_err)     ovf_r <= 1'b0;
      if (rd_en & ~rd_acc)  udf_r <= 1'b1;
      else if (clr_err)     udf_r <= 1'b0;
    end
  end

  if (MODE == MODE_STD) begin : g_std
    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;

    // ---- registered read stage: head word captured on the accepting edge ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        vld_p1 <= rd_acc;
        if (rd_acc) dout_p1 <= ram_rdata;
      end
    end

    assign dout       = dout_p1;
    assign dout_valid = vld_p1;
  end else begin : g_fwft
    // Head word is shown directly; zeroed while empty so reset reads as 0.
    assign dout       = empty_r ? '0 : ram_rdata;
    assign dout_valid = ~empty_r;
  end

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign count        = count_r;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;

endmodule

// File: tb/tb_util_fifo_param.sv
// Directed bench for util_fifo_param: one standard-mode and one FWFT instance,
// both DEPTH=8, AF_THRESH=6, AE_THRESH=2.
module tb_util_fifo_param;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          s_wr_en = 1'b0, s_rd_en = 1'b0, s_clr_err = 1'b0;
  logic [DW-1:0] s_din = '0, s_dout;
  logic          s_dout_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [CW-1:0] s_count;

  logic          f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [DW-1:0] f_din = '0, f_dout;
  logic          f_dout_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0] f_count;

  int vectors     = 0;
  int miscompares = 0;

  util_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .din(s_din), .rd_en(s_rd_en),
    .dout(s_dout), .dout_valid(s_dout_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(s_clr_err)
  );

  util_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (s_count !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", s_count); end
    vectors++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin miscompares++; $display("FAIL rst_flags e/ae/f/af: got %b want 1100", {s_empty, s_ae, s_full, s_af}); end
    vectors++; if ({s_dout_valid, s_ovf, s_udf} !== 3'b000) begin miscompares++; $display("FAIL rst_vld_err: got %b want 000", {s_dout_valid, s_ovf, s_udf}); end
    vectors++; if (s_dout !== 16'd0) begin miscompares++; $display("FAIL rst_dout: got %0d want 0", s_dout); end
    vectors++; if ({f_dout_valid, f_empty} !== 2'b01 || f_dout !== 16'd0) begin miscompares++; $display("FAIL rst_fwft: got vld/empty %b dout %0d want 01 / 0", {f_dout_valid, f_empty}, f_dout); end
    tick();
    vectors++; if (s_empty !== 1'b1) begin miscompares++; $display("FAIL rst_held_empty: got %b want 1", s_empty); end
    rst_n = 1'b1;
  endtask

  task automatic test_ordering();
    for (int i = 1; i <= 8; i++) begin
      s_wr_en = 1'b1; s_din = DW'(i);
      tick();
      s_wr_en = 1'b0;
      vectors++; if (s_count !== CW'(i)) begin miscompares++; $display("FAIL ord_count_w%0d: got %0d want %0d", i, s_count, i); end
      tick();
    end
    vectors++; if ({s_full, s_af} !== 2'b11) begin miscompares++; $display("FAIL ord_full: got %b want 11", {s_full, s_af}); end
    for (int i = 1; i <= 8; i++) begin
      s_rd_en = 1'b1;
      tick();
      s_rd_en = 1'b0;
      vectors++; if (s_dout !== DW'(i) || s_dout_valid !== 1'b1) begin miscompares++; $display("FAIL ord_read%0d: got %0d vld %b want %0d vld 1", i, s_dout, s_dout_valid, i); end
      tick();
      vectors++; if (s_dout_valid !== 1'b0 || s_dout !== DW'(i)) begin miscompares++; $display("FAIL ord_hold%0d: got %0d vld %b want %0d vld 0", i, s_dout, s_dout_valid, i); end
    end
    vectors++; if ({s_empty, s_count} !== {1'b1, 4'd0}) begin miscompares++; $display("FAIL ord_empty: got empty %b count %0d want 1 0", s_empty, s_count); end
  endtask

  task automatic test_overflow();
    s_wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_din = DW'(i);
      tick();
    end
    s_din = 16'd4095;
    tick();
    s_wr_en = 1'b0;
    vectors++; if (s_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", s_ovf); end
    vectors++; if (s_count !== 4'd8 || s_full !== 1'b1) begin miscompares++; $display("FAIL ovf_count: got %0d full %b want 8 1", s_count, s_full); end
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    vectors++; if (s_dout !== 16'd1 || s_count !== 4'd7 || s_full !== 1'b0) begin miscompares++; $display("FAIL ovf_first_read: got %0d cnt %0d full %b want 1 7 0", s_dout, s_count, s_full); end
    s_clr_err = 1'b1;
    tick();
    s_clr_err = 1'b0;
    vectors++; if (s_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b want 0", s_ovf); end
    for (int i = 2; i <= 8; i++) begin
      s_rd_en = 1'b1;
      tick();
      vectors++; if (s_dout !== DW'(i)) begin miscompares++; $display("FAIL ovf_drain%0d: got %0d want %0d", i, s_dout, i); end
    end
    s_rd_en = 1'b0;
    vectors++; if (s_empty !== 1'b1) begin miscompares++; $display("FAIL ovf_empty: got %b want 1", s_empty); end
  endtask

  task automatic test_simultaneous();
    s_wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_din = DW'(i);
      tick();
    end
    s_rd_en = 1'b1; s_din = 16'd9;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    vectors++; if (s_count !== 4'd8 || s_full !== 1'b1) begin miscompares++; $display("FAIL sim_count: got %0d full %b want 8 1", s_count, s_full); end
    vectors++; if (s_dout !== 16'd1 || s_ovf !== 1'b0) begin miscompares++; $display("FAIL sim_head: got %0d ovf %b want 1 0", s_dout, s_ovf); end
    for (int i = 1; i <= 8; i++) begin
      s_rd_en = 1'b1;
      tick();
      vectors++; if (s_dout !== DW'(i + 1)) begin miscompares++; $display("FAIL sim_drain%0d: got %0d want %0d", i, s_dout, i + 1); end
    end
    s_rd_en = 1'b0;
    vectors++; if (s_empty !== 1'b1 || s_udf !== 1'b0) begin miscompares++; $display("FAIL sim_empty: got empty %b udf %b want 1 0", s_empty, s_udf); end
  endtask

  task automatic test_underflow();
    pulse_reset();
    s_rd_en = 1'b1; s_wr_en = 1'b1; s_din = 16'd2;
    tick();
    s_rd_en = 1'b0; s_wr_en = 1'b0;
    vectors++; if (s_udf !== 1'b1) begin miscompares++; $display("FAIL udf_set: got %b want 1", s_udf); end
    vectors++; if (s_count !== 4'd1 || s_dout_valid !== 1'b0 || s_empty !== 1'b0) begin miscompares++; $display("FAIL udf_count: got cnt %0d vld %b empty %b want 1 0 0", s_count, s_dout_valid, s_empty); end
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    vectors++; if (s_dout !== 16'd2 || s_dout_valid !== 1'b1 || s_empty !== 1'b1) begin miscompares++; $display("FAIL udf_read: got %0d vld %b empty %b want 2 1 1", s_dout, s_dout_valid, s_empty); end
    s_rd_en = 1'b1; s_clr_err = 1'b1;
    tick();
    s_rd_en = 1'b0;
    vectors++; if (s_udf !== 1'b1) begin miscompares++; $display("FAIL udf_set_beats_clr: got %b want 1", s_udf); end
    tick();
    s_clr_err = 1'b0;
    vectors++; if (s_udf !== 1'b0) begin miscompares++; $display("FAIL udf_clr: got %b want 0", s_udf); end
  endtask

  task automatic test_fwft();
    vectors++; if (f_dout_valid !== 1'b0) begin miscompares++; $display("FAIL fwft_idle_vld: got %b want 0", f_dout_valid); end
    f_wr_en = 1'b1; f_din = 16'd1023;
    tick();
    f_wr_en = 1'b0;
    vectors++; if (f_dout !== 16'd1023 || f_dout_valid !== 1'b1) begin miscompares++; $display("FAIL fwft_first: got %0d vld %b want 1023 1", f_dout, f_dout_valid); end
    vectors++; if (f_ae !== 1'b1 || f_count !== 4'd1) begin miscompares++; $display("FAIL fwft_ae1: got ae %b cnt %0d want 1 1", f_ae, f_count); end
    for (int i = 2; i <= 6; i++) begin
      f_wr_en = 1'b1; f_din = DW'(i * 10);
      tick();
      if (i == 5) begin
        vectors++; if (f_af !== 1'b0) begin miscompares++; $display("FAIL fwft_af_at5: got %b want 0", f_af); end
      end
    end
    f_wr_en = 1'b0;
    vectors++; if (f_af !== 1'b1 || f_ae !== 1'b0 || f_count !== 4'd6) begin miscompares++; $display("FAIL fwft_af6: got af %b ae %b cnt %0d want 1 0 6", f_af, f_ae, f_count); end
    vectors++; if (f_dout !== 16'd1023) begin miscompares++; $display("FAIL fwft_head_hold: got %0d want 1023", f_dout); end
    f_rd_en = 1'b1;
    tick();
    for (int i = 2; i <= 6; i++) begin
      vectors++; if (f_dout !== DW'(i * 10) || f_dout_valid !== 1'b1) begin miscompares++; $display("FAIL fwft_pop%0d: got %0d vld %b want %0d 1", i, f_dout, f_dout_valid, i * 10); end
      tick();
    end
    f_rd_en = 1'b0;
    vectors++; if ({f_dout_valid, f_empty, f_ae} !== 3'b011) begin miscompares++; $display("FAIL fwft_drained: got vld/empty/ae %b want 011", {f_dout_valid, f_empty, f_ae}); end
  endtask

  task automatic test_reset_mid();
    s_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_din = DW'(50 + i);
      tick();
    end
    s_wr_en = 1'b0;
    vectors++; if (s_count !== 4'd5) begin miscompares++; $display("FAIL mid_prefill: got %0d want 5", s_count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (s_empty !== 1'b1 || s_count !== 4'd0) begin miscompares++; $display("FAIL mid_async: got empty %b cnt %0d want 1 0", s_empty, s_count); end
    rst_n = 1'b1;
    s_wr_en = 1'b1; s_din = 16'h0100;
    tick();
    vectors++; if (s_count !== 4'd1) begin miscompares++; $display("FAIL mid_first_write: got %0d want 1", s_count); end
    s_rd_en = 1'b1;
    for (int i = 1; i < 3 * DEPTH; i++) begin
      s_din = DW'(16'h0100 + i);
      tick();
      vectors++; if (s_dout !== DW'(16'h0100 + i - 1) || s_count !== 4'd1) begin miscompares++; $display("FAIL wrap%0d: got %0h cnt %0d want %0h 1", i, s_dout, s_count, 16'h0100 + i - 1); end
    end
    s_wr_en = 1'b0;
    tick();
    s_rd_en = 1'b0;
    vectors++; if (s_dout !== 16'h0117 || s_empty !== 1'b1) begin miscompares++; $display("FAIL wrap_last: got %0h empty %b want 117 1", s_dout, s_empty); end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_overflow();
    test_simultaneous();
    test_underflow();
    test_fwft();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
